ram_fifo_ctrl: RTL and testbench
================================

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, word width; shall match the attached dual-port RAM data width.
REQ-002 Parameter ADDR_W, default 4, RAM address width; depth = 2**ADDR_W = 16.
REQ-003 Clocking: single clock `clk`; reset `rst` is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 wr_en  input  1  push request.
REQ-007 wr_data  input  DATA_W  push data.
REQ-008 full  output  1  FIFO holds 16 words.
REQ-009 overflow  output  1  one-cycle pulse: push rejected.
REQ-010 rd_en  input  1  pop request.
REQ-011 rd_data  output  DATA_W  popped word, valid while rd_valid=1.
REQ-012 rd_valid  output  1  one-cycle pulse per popped word.
REQ-013 empty  output  1  FIFO holds 0 words.
REQ-014 underflow  output  1  one-cycle pulse: pop rejected.
REQ-015 count  output  ADDR_W+1  words stored, 0..16.
REQ-016 ram_addr_0, ram_we_0, ram_re_0  output  ADDR_W/1/1  RAM port 0 (write port).
REQ-017 ram_data_0  inout  DATA_W  RAM port 0 data; driven only while ram_we_0=1, else high-Z.
REQ-018 ram_addr_1, ram_we_1, ram_re_1  output  ADDR_W/1/1  RAM port 1 (read port).
REQ-019 ram_data_1  inout  DATA_W  RAM port 1 data; never driven by this block (always high-Z).

Function
REQ-020 Push is accepted at a rising edge iff wr_en=1 and full=0; pop is accepted iff rd_en=1 and empty=0.
REQ-021 Push accepted at edge N: ram_addr_0<=wptr, ram_we_0<=1, registered data<=wr_data, all at edge N; the RAM writes at edge N+1; wptr<=wptr+1.
REQ-022 ram_we_0 deasserts at edge N+1 unless another push is accepted there; ram_re_0 and ram_we_1 are tied 0.
REQ-023 Pop accepted at edge N: ram_addr_1<=rptr, ram_re_1<=1 at edge N; the RAM presents data on ram_data_1 after edge N+1; rd_data<=ram_data_1 and rd_valid<=1 at edge N+2; rptr<=rptr+1.
REQ-024 Read latency from pop acceptance to rd_valid is exactly 2 cycles; back-to-back pops yield back-to-back rd_valid.
REQ-025 wptr and rptr are ADDR_W bits and wrap 15->0 with no extra state.
REQ-026 count updates at the acceptance edge: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-027 full = (count==16); empty = (count==0); both are combinational from registered count.
REQ-028 When full, a simultaneous pop is accepted but the push is rejected, with overflow=1 for one cycle and the data dropped.
REQ-029 When empty, a simultaneous push is accepted but the pop is rejected, with underflow=1 for one cycle and no rd_valid for that request.
REQ-030 A pop accepted the cycle after a push to the same address returns the new data; the RAM write at N+1 precedes the read at N+2.
REQ-031 Words pop in strict push order; no word is duplicated or lost except rejected pushes.

Reset
REQ-032 When rst=1 at an edge: wptr, rptr, count, rd_data, ram_addr_0, ram_addr_1 are set to 0; rd_valid, overflow, underflow, ram_we_0, ram_re_1 are set to 0; the RAM data drivers go to high-Z.
REQ-033 After reset: empty=1, full=0.
REQ-034 An in-flight read pending at reset is discarded; no rd_valid is issued after reset for it.
REQ-035 wr_en and rd_en are ignored while rst=1.
REQ-036 RAM contents are not cleared by reset.

Verification
REQ-037 Reset, then push i*i for i=0..15 -> count=16, full=1 after the 16th edge, ram_we_0 pulses 16 times at addresses 0..15.
REQ-038 At full, push 0xAA -> overflow=1 for one cycle, count stays 16; pop 16 -> rd_data 0,1,4,...,225 in order, rd_valid 2 cycles after each pop, empty=1 at end.
REQ-039 At empty, rd_en=1 for one cycle -> underflow=1 for one cycle, rd_valid stays 0, count=0.
REQ-040 At count=5, wr_en=rd_en=1 for 3 cycles -> count stays 5, popped words are the oldest 3, pushed words are appended.
REQ-041 Wrap test: push 10, pop 10, push 10, pop 10 -> wptr=rptr=4, all 20 words read back correctly across address 15->0.
REQ-042 Pop accepted, then rst=1 on the next edge -> no rd_valid, count=0, empty=1, ram_re_1=0.

Source files
------------

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: 16-deep FIFO controller that keeps its storage in an external
// dual-port RAM. Port 0 is used only for writes, port 1 only for reads; the RAM
// writes one cycle after a push is accepted and returns read data one cycle
// after a pop is accepted, so popped words appear two cycles after acceptance.
module ram_fifo_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              overflow,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              underflow,
    output logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] ram_addr_0,
    output logic              ram_we_0,
    output logic              ram_re_0,
    inout  wire  [DATA_W-1:0] ram_data_0,
    output logic [ADDR_W-1:0] ram_addr_1,
    output logic              ram_we_1,
    output logic              ram_re_1,
    inout  wire  [DATA_W-1:0] ram_data_1
);

    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W-1:0] PTR_ONE  = 1;
    localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [DATA_W-1:0] wr_data_q;
    logic              rd_pend;
    logic              push_ok;
    logic              pop_ok;

    // Occupancy flags come straight from the registered count.
    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);

    // A full FIFO still accepts a pop and an empty one still accepts a push.
    assign push_ok = wr_en && !full;
    assign pop_ok  = rd_en && !empty;

    // Port 0 never reads and port 1 never writes.
    assign ram_re_0 = 1'b0;
    assign ram_we_1 = 1'b0;

    // Write data is driven onto the RAM bus only during the write cycle.
    assign ram_data_0 = ram_we_0 ? wr_data_q : {DATA_W{1'bz}};
    assign ram_data_1 = {DATA_W{1'bz}};

    // Write side: register address/data for the RAM and advance the write pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr       <= '0;
            ram_addr_0 <= '0;
            ram_we_0   <= 1'b0;
            wr_data_q  <= '0;
            overflow   <= 1'b0;
        end else begin
            ram_we_0 <= push_ok;
            overflow <= wr_en && !push_ok;
            if (push_ok) begin
                ram_addr_0 <= wptr;
                wr_data_q  <= wr_data;
                wptr       <= wptr + PTR_ONE;
            end
        end
    end

    // Read side: issue the RAM read, then capture the returned word one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            rptr       <= '0;
            ram_addr_1 <= '0;
            ram_re_1   <= 1'b0;
            rd_pend    <= 1'b0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            ram_re_1  <= pop_ok;
            rd_pend   <= ram_re_1;
            rd_valid  <= rd_pend;
            underflow <= rd_en && !pop_ok;
            if (pop_ok) begin
                ram_addr_1 <= rptr;
                rptr       <= rptr + PTR_ONE;
            end
            if (rd_pend) begin
                rd_data <= ram_data_1;
            end
        end
    end

    // Occupancy tracks accepted pushes and pops; simultaneous ones cancel.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: drives ram_fifo_ctrl against a behavioural dual-port RAM and
// compares every cycle with a queue-based FIFO reference model.
module tb_ram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic       full, overflow, rd_valid, empty, underflow;
    logic [7:0] rd_data;
    logic [4:0] count;
    logic [3:0] ram_addr_0, ram_addr_1;
    logic       ram_we_0, ram_re_0, ram_we_1, ram_re_1;
    wire  [7:0] ram_data_0;
    wire  [7:0] ram_data_1;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [7:0] model_q[$];
    int         cyc = 0;
    int         model_wptr = 0;
    int         model_rptr = 0;
    bit         exp_valid[int];
    logic [7:0] exp_data[int];
    logic       exp_ovf, exp_unf, exp_push, exp_pop;
    int         exp_waddr, exp_raddr;
    int         we_pulses;

    // Behavioural RAM
    logic [7:0] mem[16];
    logic [7:0] ram_q;
    logic       ram_oe = 1'b0;

    always #5 clk = ~clk;

    // RAM writes on port 0, registered read on port 1 driven for the following cycle.
    always @(posedge clk) begin
        if (ram_we_0) mem[ram_addr_0] <= ram_data_0;
        if (ram_re_1) ram_q <= mem[ram_addr_1];
        ram_oe <= ram_re_1;
    end

    assign ram_data_1 = ram_oe ? ram_q : 8'bz;

    ram_fifo_ctrl #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .overflow   (overflow),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .empty      (empty),
        .underflow  (underflow),
        .count      (count),
        .ram_addr_0 (ram_addr_0),
        .ram_we_0   (ram_we_0),
        .ram_re_0   (ram_re_0),
        .ram_data_0 (ram_data_0),
        .ram_addr_1 (ram_addr_1),
        .ram_we_1   (ram_we_1),
        .ram_re_1   (ram_re_1),
        .ram_data_1 (ram_data_1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // One clock of stimulus; the model computes what the FIFO must do, then outputs are checked.
    task automatic applyStimulus(input logic w, input logic [7:0] d, input logic r, input logic rs);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        rst     = rs;
        @(posedge clk);
        cyc++;
        if (rs) begin
            model_q.delete();
            exp_valid.delete();
            exp_data.delete();
            model_wptr = 0;
            model_rptr = 0;
            exp_ovf  = 1'b0;
            exp_unf  = 1'b0;
            exp_push = 1'b0;
            exp_pop  = 1'b0;
        end else begin
            exp_push = w && (model_q.size() < 16);
            exp_pop  = r && (model_q.size() > 0);
            exp_ovf  = w && !exp_push;
            exp_unf  = r && !exp_pop;
            if (exp_pop) begin
                exp_valid[cyc + 2] = 1'b1;
                exp_data[cyc + 2]  = model_q.pop_front();
                exp_raddr  = model_rptr;
                model_rptr = (model_rptr + 1) % 16;
            end
            if (exp_push) begin
                model_q.push_back(d);
                exp_waddr  = model_wptr;
                model_wptr = (model_wptr + 1) % 16;
            end
        end
        #1;
        checkOutput("count", 32'(count), 32'(model_q.size()));
        checkOutput("full", 32'(full), 32'(model_q.size() == 16));
        checkOutput("empty", 32'(empty), 32'(model_q.size() == 0));
        checkOutput("overflow", 32'(overflow), 32'(exp_ovf));
        checkOutput("underflow", 32'(underflow), 32'(exp_unf));
        checkOutput("rd_valid", 32'(rd_valid), 32'(exp_valid.exists(cyc)));
        checkOutput("ram_we_0", 32'(ram_we_0), 32'(exp_push));
        checkOutput("ram_re_1", 32'(ram_re_1), 32'(exp_pop));
        if (ram_we_0) we_pulses++;
        if (exp_push) checkOutput("ram_addr_0", 32'(ram_addr_0), 32'(exp_waddr));
        if (exp_pop) checkOutput("ram_addr_1", 32'(ram_addr_1), 32'(exp_raddr));
        if (rs) begin
            checkOutput("rd_data_rst", 32'(rd_data), 32'd0);
            checkOutput("ram_addr_0_rst", 32'(ram_addr_0), 32'd0);
        end
        if (exp_valid.exists(cyc)) checkOutput("rd_data", 32'(rd_data), 32'(exp_data[cyc]));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; rst = 1'b1;
        applyStimulus(1'b1, 8'h55, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("ram_re_0_tie", 32'(ram_re_0), 32'd0);
        checkOutput("ram_we_1_tie", 32'(ram_we_1), 32'd0);

        // Fill with squares, then overflow attempt while full.
        we_pulses = 0;
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(i * i), 1'b0, 1'b0);
        checkOutput("fill_full", 32'(full), 32'd1);
        applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
        checkOutput("fill_we_pulses", 32'(we_pulses), 32'd16);
        checkOutput("ovf_count", 32'(count), 32'd16);

        // Pop everything back out in push order.
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        idle(3);
        checkOutput("drain_empty", 32'(empty), 32'd1);

        // Underflow on an empty FIFO.
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        idle(3);

        // Simultaneous push/pop at count=5.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'h30 + i), 1'b1, 1'b0);
        checkOutput("simul_count", 32'(count), 32'd5);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        idle(3);

        // Wrap test from a fresh reset.
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'(8'h80 + k * 10 + i), 1'b0, 1'b0);
            for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            idle(2);
        end
        checkOutput("wrap_wptr", 32'(model_wptr), 32'd4);
        applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0);
        checkOutput("wrap_addr", 32'(ram_addr_0), 32'd4);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        idle(3);

        // Pop immediately followed by reset must produce no rd_valid.
        applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        idle(4);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 99) < 55), 8'($urandom),
                          1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 99) < 2));
        end
        for (int i = 0; i < 18; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        idle(3);
        checkOutput("final_empty", 32'(empty), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
